// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: receiver state encoding and
// counter sizing shared by the UART receive slice.
package uart_rx_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      START  = ST_START,
      DATA   = ST_DATA,
      PARITY = ST_PARITY,
      STOP   = ST_STOP
   } rx_state_e;

   // Width of a counter that must hold 0 .. n-1.
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit oversampling counter and
// three-point majority vote around mid-bit.
module uart_rx_sampler
   import uart_rx_pkg::*;
#(
   parameter int PRESCALE = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic active,
   input  logic rx_s,
   output logic sample_bit,
   output logic sample_strobe,
   output logic bit_tick
);

   localparam int CW = cnt_w(PRESCALE);
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
   localparam logic [CW-1:0] SP0  = CW'(PRESCALE / 2 - 1);
   localparam logic [CW-1:0] SP1  = CW'(PRESCALE / 2);
   localparam logic [CW-1:0] SP2  = CW'(PRESCALE / 2 + 1);

   logic [CW-1:0] edge_cnt;
   logic [1:0]    samples;

   // Edge counter: held at 0 while idle, wraps once per bit.
   always_ff @(posedge clk) begin
      if (rst || !active) begin
         edge_cnt <= '0;
      end else if (edge_cnt == LAST) begin
         edge_cnt <= '0;
      end else begin
         edge_cnt <= edge_cnt + 1'b1;
      end
   end

   // Capture the first two of the three mid-bit samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         samples <= 2'b11;
      end else if (active) begin
         if (edge_cnt == SP0) samples[0] <= rx_s;
         if (edge_cnt == SP1) samples[1] <= rx_s;
      end
   end

   // Third sample is the live line, so the vote is ready at SP2.
   always_comb begin
      sample_bit    = (samples[0] & samples[1]) |
                      (samples[0] & rx_s) |
                      (samples[1] & rx_s);
      sample_strobe = active && (edge_cnt == SP2);
      bit_tick      = active && (edge_cnt == LAST);
   end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: synchronizes the serial line, frames start/data/
// parity/stop bits and reports the byte or frame errors.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int PRESCALE = 8,
   parameter int DATA_W   = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_RX_IN,
   input  logic              i_PAR_EN,
   input  logic              i_PAR_TYP,
   output logic [DATA_W-1:0] o_P_DATA,
   output logic              o_data_valid,
   output logic              o_par_err,
   output logic              o_stp_err
);

   localparam int BW = cnt_w(DATA_W);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

   rx_state_e         state;
   logic              rx_meta;
   logic              rx_s;
   logic              rx_d;
   logic              fall_q;
   logic [BW-1:0]     bit_cnt;
   logic [DATA_W-1:0] shift_reg;
   logic              par_en_q;
   logic              par_typ_q;
   logic              par_bad;
   logic              sample_bit;
   logic              sample_strobe;
   logic              bit_tick;

   // Two-flop synchronizer, delayed copy and a registered
   // falling-edge flag that keeps the idle decode shallow.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_d    <= 1'b1;
         fall_q  <= 1'b0;
      end else begin
         rx_meta <= i_RX_IN;
         rx_s    <= rx_meta;
         rx_d    <= rx_s;
         fall_q  <= rx_d & ~rx_s;
      end
   end

   uart_rx_sampler #(
      .PRESCALE (PRESCALE)
   ) u_sampler (
      .clk           (i_clk),
      .rst           (i_rst),
      .active        (state != IDLE),
      .rx_s          (rx_s),
      .sample_bit    (sample_bit),
      .sample_strobe (sample_strobe),
      .bit_tick      (bit_tick)
   );

   // Frame FSM: deserialize, check parity and stop, emit pulses.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state        <= IDLE;
         bit_cnt      <= '0;
         shift_reg    <= '0;
         par_en_q     <= 1'b0;
         par_typ_q    <= 1'b0;
         par_bad      <= 1'b0;
         o_P_DATA     <= '0;
         o_data_valid <= 1'b0;
         o_par_err    <= 1'b0;
         o_stp_err    <= 1'b0;
      end else begin
         o_data_valid <= 1'b0;
         o_par_err    <= 1'b0;
         o_stp_err    <= 1'b0;
         unique case (state)
            IDLE: begin
               if (fall_q) begin
                  state     <= START;
                  bit_cnt   <= '0;
                  par_en_q  <= i_PAR_EN;
                  par_typ_q <= i_PAR_TYP;
                  par_bad   <= 1'b0;
               end
            end
            START: begin
               if (sample_strobe && sample_bit) begin
                  state <= IDLE;
               end else if (bit_tick) begin
                  state <= DATA;
               end
            end
            DATA: begin
               if (sample_strobe) begin
                  shift_reg <= {sample_bit, shift_reg[DATA_W-1:1]};
               end
               if (bit_tick) begin
                  if (bit_cnt == LAST_BIT) begin
                     bit_cnt <= '0;
                     state   <= par_en_q ? PARITY : STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            PARITY: begin
               if (sample_strobe) begin
                  par_bad <= sample_bit ^ (^shift_reg) ^ par_typ_q;
               end
               if (bit_tick) begin
                  state <= STOP;
               end
            end
            STOP: begin
               if (sample_strobe) begin
                  state        <= IDLE;
                  o_data_valid <= sample_bit && !par_bad;
                  o_par_err    <= par_bad;
                  o_stp_err    <= !sample_bit;
                  if (sample_bit && !par_bad) begin
                     o_P_DATA <= shift_reg;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: frame-level reference model of the receiver
// compared against every output pulse the DUT produces.
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int P = 8;

   typedef logic [42:0] ev_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       pen;
   logic       ptyp;
   logic [7:0] pdata;
   logic       dv;
   logic       pe;
   logic       se;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   ev_t  got_q[$];
   ev_t  exp_q[$];
   logic [7:0] last_good;

   uart_rx #(
      .PRESCALE (P),
      .DATA_W   (8)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_RX_IN      (rx),
      .i_PAR_EN     (pen),
      .i_PAR_TYP    (ptyp),
      .o_P_DATA     (pdata),
      .o_data_valid (dv),
      .o_par_err    (pe),
      .o_stp_err    (se)
   );

   always #5 clk = ~clk;

   // Cycle number N means "the cycle after posedge N".
   always @(posedge clk) cyc <= cyc + 1;

   // Record every pulse as {cycle, valid, par_err, stp_err, data}.
   always @(negedge clk) begin
      if (dv | pe | se) got_q.push_back({32'(cyc), dv, pe, se, pdata});
   end

   task automatic hold(input logic v, input int n);
      rx = v;
      repeat (n) @(negedge clk);
   endtask

   // Send one frame and predict its single pulse event.
   task automatic send_frame(input logic [7:0] d, input logic par_en,
                             input logic par_typ, input logic bad_par,
                             input logic stop_bit, input int gap);
      logic perr;
      logic serr;
      logic ok;
      logic pbit;
      int   nbits;
      pen   = par_en;
      ptyp  = par_typ;
      perr  = par_en & bad_par;
      serr  = ~stop_bit;
      ok    = !perr && !serr;
      if (ok) last_good = d;
      nbits = 10 + int'(par_en);
      exp_q.push_back({32'(cyc + 1 + 3 + (nbits - 1) * P + P / 2 + 2),
                       ok, perr, serr, last_good});
      hold(1'b0, P);
      pen  = 1'($urandom);
      ptyp = 1'($urandom);
      for (int i = 0; i < 8; i++) hold(d[i], P);
      if (par_en) begin
         pbit = 1'($countones(d) % 2) ^ par_typ ^ bad_par;
         hold(pbit, P);
      end
      hold(stop_bit, P);
      hold(1'b1, gap * P);
   endtask

   task automatic test_reset();
      rst  = 1'b1;
      rx   = 1'b1;
      pen  = 1'b0;
      ptyp = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({pdata, dv, pe, se} !== 11'h0) begin
         errors++;
         $display("FAIL reset_outputs: got data=%h v=%b pe=%b se=%b, want all 0",
                  pdata, dv, pe, se);
      end
      rst = 1'b0;
      last_good = 8'h00;
      hold(1'b1, 2 * P);
   endtask

   task automatic test_basic();
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 2);
      send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 2);
      send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 3);
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL basic_count: got %0d events, want %0d",
                  got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL basic_ev%0d: got cyc/v/pe/se/d %h, want %h",
                     i, got_q[i], exp_q[i]);
         end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_stop_err();
      send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      hold(1'b0, 20 * P);
      hold(1'b1, 2 * P);
      send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 3);
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL stop_count: got %0d events, want %0d",
                  got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL stop_ev%0d: got cyc/v/pe/se/d %h, want %h",
                     i, got_q[i], exp_q[i]);
         end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_glitch();
      hold(1'b0, 3);
      hold(1'b1, 2 * P);
      send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 3);
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL glitch_count: got %0d events, want %0d",
                  got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL glitch_ev%0d: got cyc/v/pe/se/d %h, want %h",
                     i, got_q[i], exp_q[i]);
         end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset_mid();
      logic [7:0] d;
      d    = 8'hC3;
      pen  = 1'b0;
      ptyp = 1'b0;
      hold(1'b0, P);
      for (int i = 0; i < 4; i++) hold(d[i], P);
      hold(d[4], 3);
      rst = 1'b1;
      rx  = 1'b1;
      @(negedge clk);
      checks++;
      if ({pdata, dv, pe, se} !== 11'h0) begin
         errors++;
         $display("FAIL midreset_outputs: got data=%h v=%b pe=%b se=%b, want all 0",
                  pdata, dv, pe, se);
      end
      rst = 1'b0;
      last_good = 8'h00;
      hold(1'b1, 2 * P);
      send_frame(8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, 3);
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL midreset_count: got %0d events, want %0d",
                  got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL midreset_ev%0d: got cyc/v/pe/se/d %h, want %h",
                     i, got_q[i], exp_q[i]);
         end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_back_to_back();
      send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 3);
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL b2b_count: got %0d events, want %0d",
                  got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL b2b_ev%0d: got cyc/v/pe/se/d %h, want %h",
                     i, got_q[i], exp_q[i]);
         end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_random();
      logic [7:0] d;
      logic       p_en;
      logic       p_typ;
      logic       bad;
      logic       stp;
      int         gap;
      for (int n = 0; n < 16; n++) begin
         d     = 8'($urandom);
         p_en  = 1'($urandom);
         p_typ = 1'($urandom);
         bad   = ($urandom_range(0, 3) == 0);
         stp   = ($urandom_range(0, 4) != 0);
         gap   = stp ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
         send_frame(d, p_en, p_typ, bad, stp, gap);
      end
      hold(1'b1, 3 * P);
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL rand_count: got %0d events, want %0d",
                  got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL rand_ev%0d: got cyc/v/pe/se/d %h, want %h",
                     i, got_q[i], exp_q[i]);
         end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      rst  = 1'b1;
      rx   = 1'b1;
      pen  = 1'b0;
      ptyp = 1'b0;
      last_good = 8'h00;
      @(negedge clk);
      test_reset();
      test_basic();
      test_stop_err();
      test_glitch();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
